// File: rtl/pll_seq_pkg.sv
// Shared types, defaults and counter sizing for the PLL lock sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK,
    LOCK_FILTER,
    RST_HOLD,
    CAL,
    RUN
  } seq_state_e;

  localparam int DEF_LOCK_CYCLES = 1024;
  localparam int DEF_RST_CYCLES  = 16;
  localparam int DEF_CAL_TIMEOUT = 1 << 20;
  localparam int DEF_LOSS_W      = 8;

  // One shared counter; it must hold the largest terminal count (max-1).
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for quasi-static level signals entering the clk domain.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Lock filter, reset hold and calibration kick-off behind the PLL wrapper.
// Optional calibration timeout enabled by defining CAL_TIMEOUT_EN.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter int RST_CYCLES  = DEF_RST_CYCLES,
  parameter int CAL_TIMEOUT = DEF_CAL_TIMEOUT,
  parameter int LOSS_W      = DEF_LOSS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pll_locked,
  input  logic              cal_done,
  output logic              sys_rst,
  output logic              cal_start,
  output logic              ready,
  output logic              cal_err,
  output logic [LOSS_W-1:0] lock_loss_cnt
);

  localparam int CW = cnt_width(LOCK_CYCLES, RST_CYCLES, CAL_TIMEOUT);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
`ifdef CAL_TIMEOUT_EN
  localparam logic [CW-1:0] CAL_LAST  = CW'(CAL_TIMEOUT - 1);
`endif

  seq_state_e    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          locked_s;
  logic          loss;
  logic          cal_to;

  sync_2ff #(.W(1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    loss     = 1'b0;
    cal_to   = 1'b0;
    case (state)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_nx = LOCK_FILTER;
          cnt_nx   = '0;
        end
      end
      LOCK_FILTER: begin
        // A drop here is a filter reject, not a counted loss.
        if (!locked_s) begin
          state_nx = WAIT_LOCK;
          cnt_nx   = '0;
        end else if (cnt == LOCK_LAST) begin
          state_nx = RST_HOLD;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      RST_HOLD: begin
        if (!locked_s) begin
          loss = 1'b1;
        end else if (cnt == RST_LAST) begin
          state_nx = CAL;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      CAL: begin
        if (!locked_s) begin
          loss = 1'b1;
        end else if (cal_done) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end
`ifdef CAL_TIMEOUT_EN
        else if (cnt == CAL_LAST) begin
          state_nx = RUN;
          cnt_nx   = '0;
          cal_to   = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
`endif
      end
      RUN: begin
        if (!locked_s) loss = 1'b1;
      end
      default: begin
        state_nx = WAIT_LOCK;
        cnt_nx   = '0;
      end
    endcase
    // Loss of lock overrides RST_HOLD expiry and cal_done.
    if (loss) begin
      state_nx = WAIT_LOCK;
      cnt_nx   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= WAIT_LOCK;
      cnt           <= '0;
      sys_rst       <= 1'b1;
      cal_start     <= 1'b0;
      ready         <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      sys_rst   <= (state_nx == WAIT_LOCK) || (state_nx == LOCK_FILTER) ||
                   (state_nx == RST_HOLD);
      cal_start <= (state_nx == CAL) && (state != CAL);
      ready     <= (state_nx == RUN);
      if (loss && (lock_loss_cnt != {LOSS_W{1'b1}}))
        lock_loss_cnt <= lock_loss_cnt + LOSS_W'(1);
    end
  end

`ifdef CAL_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst)         cal_err <= 1'b0;
    else if (cal_to) cal_err <= 1'b1;
  end
`else
  assign cal_err = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed + randomized bench for pll_lock_sequencer with a timestamp-based reference model.
module tb_pll_lock_sequencer;

  localparam int L      = 8;
  localparam int R      = 4;
  localparam int TO     = 20;
  localparam int LW     = 2;
  localparam int LMAX   = (1 << LW) - 1;
`ifdef CAL_TIMEOUT_EN
  localparam bit TO_EN  = 1'b1;
`else
  localparam bit TO_EN  = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pll_locked = 1'b0;
  logic          cal_done = 1'b0;
  logic          sys_rst, cal_start, ready, cal_err;
  logic [LW-1:0] lock_loss_cnt;

  pll_lock_sequencer #(
    .LOCK_CYCLES (L),
    .RST_CYCLES  (R),
    .CAL_TIMEOUT (TO),
    .LOSS_W      (LW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .cal_done      (cal_done),
    .sys_rst       (sys_rst),
    .cal_start     (cal_start),
    .ready         (ready),
    .cal_err       (cal_err),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n = 0;

  // Reference model: pll_locked history, and the edge at which the current lock
  // attempt began; everything else is arithmetic on edges since that point.
  bit m_s1, m_s2, m_active, m_run, m_err;
  int m_a, m_loss;
  int cs_edge = -1000;
  bit e_sys_rst, e_cal_start, e_ready;

  bit prev_sys_rst = 1'b1;
  int fall_edge = -1;
  int cs_obs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit ls;
    int t, k;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_active = 0; m_run = 0; m_err = 0; m_loss = 0;
    end else begin
      ls   = m_s2;
      m_s2 = m_s1;
      m_s1 = pll_locked;
      if (!m_active) begin
        if (ls) begin m_active = 1; m_a = n; m_run = 0; end
      end else begin
        t = n - m_a;
        if (!ls) begin
          if (t > L && m_loss < LMAX) m_loss++;
          m_active = 0;
          m_run    = 0;
        end else if (t > L + R && !m_run) begin
          k = t - L - R;
          if (cal_done) m_run = 1;
          else if (TO_EN && k == TO) begin m_run = 1; m_err = 1; end
        end
      end
    end
    e_sys_rst   = !(m_active && (n - m_a) >= L + R);
    e_cal_start = m_active && (n - m_a) == L + R;
    e_ready     = m_active && m_run;
    if (e_cal_start) cs_edge = n;
  endtask

  task automatic step(input logic r, input logic pl, input logic cd);
    @(negedge clk);
    rst = r; pll_locked = pl; cal_done = cd;
    @(posedge clk);
    n++;
    model_edge();
    #1;
    chk("sys_rst", 32'(sys_rst), 32'(e_sys_rst));
    chk("cal_start", 32'(cal_start), 32'(e_cal_start));
    chk("ready", 32'(ready), 32'(e_ready));
    chk("cal_err", 32'(cal_err), 32'(m_err));
    chk("lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_loss));
    if (prev_sys_rst && !sys_rst) fall_edge = n;
    prev_sys_rst = sys_rst;
    if (cal_start) cs_obs++;
  endtask

  // Hold pll_locked; answer cal_start with a cal_done sampled 'delay' edges later (delay<0: never).
  task automatic run(input int cycles, input logic pl, input int delay);
    for (int i = 0; i < cycles; i++)
      step(1'b0, pl, (delay >= 0) && (n + 1 == cs_edge + delay));
  endtask

  initial begin
    int e0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    chk("reset_sys_rst", 32'(sys_rst), 32'd1);
    chk("reset_loss", 32'(lock_loss_cnt), 32'd0);

    // Clean lock
    fall_edge = -1; cs_obs = 0;
    step(1'b0, 1'b1, 1'b0);
    e0 = n;
    run(30, 1'b1, 3);
    chk("clean_latency", 32'(fall_edge - e0), 32'd14);
    chk("clean_cal_start_once", 32'(cs_obs), 32'd1);
    chk("clean_ready", 32'(ready), 32'd1);

    // Filter glitch
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    fall_edge = -1;
    run(5, 1'b1, -1);
    run(1, 1'b0, -1);
    step(1'b0, 1'b1, 1'b0);
    e0 = n;
    run(30, 1'b1, 3);
    chk("glitch_latency", 32'(fall_edge - e0), 32'd14);
    chk("glitch_no_loss", 32'(lock_loss_cnt), 32'd0);

    // Loss in RUN, then relock
    run(3, 1'b0, -1);
    chk("loss_sys_rst", 32'(sys_rst), 32'd1);
    chk("loss_ready", 32'(ready), 32'd0);
    chk("loss_cnt1", 32'(lock_loss_cnt), 32'd1);
    run(30, 1'b1, 3);
    chk("relock_ready", 32'(ready), 32'd1);

    // Saturation: four more losses
    for (int i = 0; i < 4; i++) begin
      run(3, 1'b0, -1);
      run(30, 1'b1, 2);
    end
    chk("loss_saturate", 32'(lock_loss_cnt), 32'(LMAX));

    // Calibration never completes
    run(3, 1'b0, -1);
    run(40, 1'b1, -1);
`ifdef CAL_TIMEOUT_EN
    chk("timeout_err", 32'(cal_err), 32'd1);
    chk("timeout_ready", 32'(ready), 32'd1);
`else
    chk("no_timeout_err", 32'(cal_err), 32'd0);
    chk("no_timeout_ready", 32'(ready), 32'd0);
`endif

    // Reset mid-CAL
    step(1'b1, 1'b1, 1'b0);
    run(16, 1'b1, -1);
    chk("midcal_sys_rst_low", 32'(sys_rst), 32'd0);
    step(1'b1, 1'b1, 1'b0);
    chk("midcal_rst_sys_rst", 32'(sys_rst), 32'd1);
    chk("midcal_rst_ready", 32'(ready), 32'd0);
    chk("midcal_rst_loss", 32'(lock_loss_cnt), 32'd0);
    chk("midcal_rst_err", 32'(cal_err), 32'd0);

    // Randomized traffic
    begin
      logic pl = 1'b1;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 59) == 0) pl = ~pl;
        step(($urandom_range(0, 699) == 0), pl, ($urandom_range(0, 5) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
